tvals_sender: RTL and testbench

TVALS_SENDER -- requirements
Module: tvals_sender

---
 rtl/tvals_sender_if.sv | 35 +++
 rtl/tvals_sender.sv | 200 ++++++++++++++++++++
 tb/tb_tvals_sender.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tvals_sender_if.sv
// Bundles the frame/sample inputs and the T-value burst outputs of tvals_sender.
// Latency: none (wires only).
// Backpressure: none; the sender side never stalls and the consumer must take every beat.
interface tvals_sender_if #(
    parameter int BIT_WIDTH    = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int I            = 160,
    parameter int FORMANTS     = 5
);
    localparam int CW = $clog2(I + 1);

    logic                              frame_start;
    logic [FORMANTS-1:0][CW-1:0]       boundary_in;
    logic signed [SAMPLE_WIDTH-1:0]    sample_in;
    logic                              sample_valid;
    logic [BIT_WIDTH-1:0]              T_vals_0;
    logic [BIT_WIDTH-1:0]              T_vals_1;
    logic [BIT_WIDTH-1:0]              T_vals_2;
    logic                              input_start;
    logic                              input_valid;
    logic                              busy;
    logic                              overrun;

    // Sender side: consumes samples, produces the T-value burst.
    modport master (
        input  frame_start, boundary_in, sample_in, sample_valid,
        output T_vals_0, T_vals_1, T_vals_2, input_start, input_valid, busy, overrun
    );

    // Source/consumer side: drives samples, observes the burst.
    modport slave (
        output frame_start, boundary_in, sample_in, sample_valid,
        input  T_vals_0, T_vals_1, T_vals_2, input_start, input_valid, busy, overrun
    );
endinterface

// File: rtl/tvals_sender.sv
// Accumulates lag-0/1/2 autocorrelation sums per frame and bursts one T-value triple per segment boundary.
// Latency: input_start two cycles after the last sample, then one gap cycle and FORMANTS back-to-back beats.
// Backpressure: none; misplaced frame_start/sample_valid are dropped and flagged on the sticky overrun.
module tvals_sender #(
    parameter int BIT_WIDTH    = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int I            = 160,
    parameter int FORMANTS     = 5,
    parameter int PROD_SHIFT   = 8,
    parameter int HOLDOFF      = 700
) (
    input  logic         clk_in,
    input  logic         rst_in,
    tvals_sender_if.master bus
);
    localparam int CW  = $clog2(I + 1);
    localparam int PW  = 2 * SAMPLE_WIDTH;
    localparam int HW  = $clog2(HOLDOFF + 1);
    localparam int BTW = $clog2(FORMANTS + 1);

    typedef enum logic [2:0] {IDLE, ACCUM, START, GAP, SEND, HOLD} state_t;

    state_t                             state;
    logic [FORMANTS-1:0][CW-1:0]        bnd;
    logic [FORMANTS-1:0][CW-1:0]        bnd_eff;
    logic [CW-1:0]                      in_cnt;
    logic [CW-1:0]                      acc_cnt;
    logic [CW-1:0]                      acc_cnt_nxt;
    logic signed [SAMPLE_WIDTH-1:0]     x1;
    logic signed [SAMPLE_WIDTH-1:0]     x2;
    logic signed [PW-1:0]               p0;
    logic signed [PW-1:0]               p1;
    logic signed [PW-1:0]               p2;
    logic                               p_vld;
    logic signed [BIT_WIDTH-1:0]        acc0;
    logic signed [BIT_WIDTH-1:0]        acc1;
    logic signed [BIT_WIDTH-1:0]        acc2;
    logic signed [BIT_WIDTH-1:0]        sum0;
    logic signed [BIT_WIDTH-1:0]        sum1;
    logic signed [BIT_WIDTH-1:0]        sum2;
    logic [FORMANTS-1:0][BIT_WIDTH-1:0] snap0;
    logic [FORMANTS-1:0][BIT_WIDTH-1:0] snap1;
    logic [FORMANTS-1:0][BIT_WIDTH-1:0] snap2;
    logic [HW-1:0]                      hold_cnt;
    logic [BTW-1:0]                     beat;
    logic [BIT_WIDTH-1:0]               t0;
    logic [BIT_WIDTH-1:0]               t1;
    logic [BIT_WIDTH-1:0]               t2;
    logic                               start_q;
    logic                               valid_q;
    logic                               overrun_q;
    logic                               accept;

    // Scale a raw product down and sign-extend (or wrap) it to accumulator width.
    function automatic logic signed [BIT_WIDTH-1:0] scale(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> PROD_SHIFT;
        return BIT_WIDTH'(s);
    endfunction

    // A sample is taken only while accumulating and before the frame is full.
    assign accept      = (state == ACCUM) && bus.sample_valid && (in_cnt < CW'(I));
    assign acc_cnt_nxt = acc_cnt + 1'b1;
    assign sum0        = acc0 + scale(p0);
    assign sum1        = acc1 + scale(p1);
    assign sum2        = acc2 + scale(p2);

    // Boundaries that are zero or beyond the frame collapse onto the full-frame count.
    always_comb begin
        bnd_eff = '0;
        for (int k = 0; k < FORMANTS; k++) begin
            bnd_eff[k] = bus.boundary_in[k];
            if (bus.boundary_in[k] == '0 || bus.boundary_in[k] > CW'(I))
                bnd_eff[k] = CW'(I);
        end
    end

    // Frame FSM with product stage, accumulators, snapshots and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            bnd       <= '0;
            in_cnt    <= '0;
            acc_cnt   <= '0;
            x1        <= '0;
            x2        <= '0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p_vld     <= 1'b0;
            acc0      <= '0;
            acc1      <= '0;
            acc2      <= '0;
            snap0     <= '0;
            snap1     <= '0;
            snap2     <= '0;
            hold_cnt  <= '0;
            beat      <= '0;
            t0        <= '0;
            t1        <= '0;
            t2        <= '0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if ((bus.frame_start && state != IDLE) || (bus.sample_valid && !accept))
                overrun_q <= 1'b1;

            // Stage 1: register the three lagged products.
            p_vld <= accept;
            if (accept) begin
                p0     <= bus.sample_in * bus.sample_in;
                p1     <= bus.sample_in * x1;
                p2     <= bus.sample_in * x2;
                x1     <= bus.sample_in;
                x2     <= x1;
                in_cnt <= in_cnt + 1'b1;
            end

            // Stage 2: accumulate and capture every segment that ends on this sample.
            if (p_vld) begin
                acc0    <= sum0;
                acc1    <= sum1;
                acc2    <= sum2;
                acc_cnt <= acc_cnt_nxt;
                for (int k = 0; k < FORMANTS; k++) begin
                    if (acc_cnt_nxt == bnd[k]) begin
                        snap0[k] <= sum0;
                        snap1[k] <= sum1;
                        snap2[k] <= sum2;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state   <= ACCUM;
                        bnd     <= bnd_eff;
                        acc0    <= '0;
                        acc1    <= '0;
                        acc2    <= '0;
                        in_cnt  <= '0;
                        acc_cnt <= '0;
                        x1      <= '0;
                        x2      <= '0;
                    end
                end
                ACCUM: begin
                    if (p_vld && acc_cnt_nxt == CW'(I)) begin
                        state    <= START;
                        start_q  <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                START: begin
                    state    <= GAP;
                    start_q  <= 1'b0;
                    hold_cnt <= hold_cnt + 1'b1;
                end
                GAP: begin
                    state    <= SEND;
                    valid_q  <= 1'b1;
                    t0       <= snap0[0];
                    t1       <= snap1[0];
                    t2       <= snap2[0];
                    beat     <= BTW'(1);
                    hold_cnt <= hold_cnt + 1'b1;
                end
                SEND: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (beat == BTW'(FORMANTS)) begin
                        state   <= HOLD;
                        valid_q <= 1'b0;
                    end else begin
                        t0   <= snap0[beat];
                        t1   <= snap1[beat];
                        t2   <= snap2[beat];
                        beat <= beat + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt >= HW'(HOLDOFF - 1))
                        state <= IDLE;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.T_vals_0    = t0;
    assign bus.T_vals_1    = t1;
    assign bus.T_vals_2    = t2;
    assign bus.input_start = start_q;
    assign bus.input_valid = valid_q;
    assign bus.busy        = (state != IDLE);
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_tvals_sender.sv
// Directed bench for tvals_sender: frames with hand-computed T-value bursts, overrun, holdoff and reset abort.
// Latency: checks input_start at c+2, gap at c+3, beats at c+4..c+8 relative to the last sample.
// Backpressure: none; the bench samples every output on the falling edge.
module tb_tvals_sender;
    localparam int NI   = 160;
    localparam int FM   = 5;
    localparam int HOLD = 700;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   bnd [FM];
    longint e0 [FM];
    longint e1 [FM];
    longint e2 [FM];
    int   t_start;
    int   pulses;

    always #5 clk = ~clk;

    // Free-running cycle count used to time holdoff checks.
    always @(posedge clk) cyc <= cyc + 1;

    tvals_sender_if bus ();
    tvals_sender dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [15:0] smp(input int pat, input int n);
        case (pat)
            0:       return 16'sd256;
            1:       return (n % 2 == 0) ? 16'sd256 : -16'sd256;
            default: return -16'sd32768;
        endcase
    endfunction

    // Expected beats for a constant or alternating +/-256 stream against the current boundaries.
    task automatic set_exp_256(input bit alt);
        for (int k = 0; k < FM; k++) begin
            e0[k] = 256 * bnd[k];
            e1[k] = alt ? -256 * (bnd[k] - 1) : 256 * (bnd[k] - 1);
            e2[k] = 256 * (bnd[k] - 2);
        end
    endtask

    task automatic run_frame(input string nm, input int pat, input int abort_beats,
                             input bit dirty, output int ts);
        ts = 0;
        @(negedge clk);
        bus.frame_start = 1'b1;
        for (int k = 0; k < FM; k++) bus.boundary_in[k] = 8'(bnd[k]);
        if (dirty) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 16'sd1000;
        end
        @(negedge clk);
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
        check({nm, " busy_accum"}, bus.busy, 1);
        for (int n = 0; n < NI; n++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = smp(pat, n);
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        check({nm, " start_c1"}, bus.input_start, 0);
        @(negedge clk);
        ts = cyc;
        check({nm, " start_c2"}, bus.input_start, 1);
        check({nm, " valid_c2"}, bus.input_valid, 0);
        @(negedge clk);
        check({nm, " gap_start"}, bus.input_start, 0);
        check({nm, " gap_valid"}, bus.input_valid, 0);
        for (int k = 0; k < FM; k++) begin
            @(negedge clk);
            check($sformatf("%s beat%0d valid", nm, k), bus.input_valid, 1);
            check($sformatf("%s beat%0d T0", nm, k), $signed(bus.T_vals_0), e0[k]);
            check($sformatf("%s beat%0d T1", nm, k), $signed(bus.T_vals_1), e1[k]);
            check($sformatf("%s beat%0d T2", nm, k), $signed(bus.T_vals_2), e2[k]);
            if (abort_beats == k + 1) return;
        end
        @(negedge clk);
        check({nm, " post_valid"}, bus.input_valid, 0);
        check({nm, " hold_T0"}, $signed(bus.T_vals_0), e0[FM-1]);
        check({nm, " hold_T2"}, $signed(bus.T_vals_2), e2[FM-1]);
    endtask

    // Busy must stay high through cycle s+HOLD-1 and drop exactly at s+HOLD.
    task automatic hold_check(input string nm, input int ts);
        while (cyc < ts + HOLD - 1) @(negedge clk);
        check({nm, " busy_holdoff_m1"}, bus.busy, 1);
        @(negedge clk);
        check({nm, " busy_holdoff"}, bus.busy, 0);
    endtask

    initial begin
        bus.frame_start  = 1'b0;
        bus.boundary_in  = '0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        #12;
        check("rst start", bus.input_start, 0);
        check("rst valid", bus.input_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst overrun", bus.overrun, 0);
        check("rst T0", bus.T_vals_0, 0);
        check("rst T1", bus.T_vals_1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant 256, even segments.
        bnd = '{32, 64, 96, 128, 160};
        set_exp_256(1'b0);
        run_frame("const", 0, 0, 1'b0, t_start);
        check("const overrun", bus.overrun, 0);
        while (cyc < t_start + 10) @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        check("early_fs overrun", bus.overrun, 1);
        check("early_fs busy", bus.busy, 1);
        hold_check("const", t_start);

        // Alternating sign, accepted right at the holdoff boundary.
        set_exp_256(1'b1);
        run_frame("alt", 1, 0, 1'b0, t_start);
        check("alt overrun_sticky", bus.overrun, 1);
        hold_check("alt", t_start);

        // Full-scale negative samples, every boundary at the frame end.
        bnd = '{160, 160, 160, 160, 160};
        for (int k = 0; k < FM; k++) begin
            e0[k] = 64'd671088640;
            e1[k] = 159 * 64'd4194304;
            e2[k] = 158 * 64'd4194304;
        end
        run_frame("neg", 2, 0, 1'b0, t_start);
        hold_check("neg", t_start);

        // Duplicate, out-of-range and zero boundaries.
        bnd = '{40, 40, 200, 0, 160};
        e0 = '{10240, 10240, 40960, 40960, 40960};
        e1 = '{9984, 9984, 40704, 40704, 40704};
        e2 = '{9728, 9728, 40448, 40448, 40448};
        run_frame("dup", 0, 0, 1'b0, t_start);
        hold_check("dup", t_start);

        // Reset after three beats aborts the burst.
        bnd = '{32, 64, 96, 128, 160};
        set_exp_256(1'b0);
        run_frame("abort", 0, 3, 1'b0, t_start);
        rst_n = 1'b0;
        #1;
        check("abort valid", bus.input_valid, 0);
        check("abort busy", bus.busy, 0);
        check("abort T0", bus.T_vals_0, 0);
        check("abort T2", bus.T_vals_2, 0);
        check("abort overrun", bus.overrun, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.input_valid) pulses++;
        end
        check("abort no_beats", pulses, 0);

        // Sample alongside frame_start is dropped; the frame itself is unaffected.
        run_frame("dirty", 0, 0, 1'b1, t_start);
        check("dirty overrun", bus.overrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
